armleocpu_tlb: RTL and testbench

Set-associative translation lookaside buffer caching Sv32 leaf translations produced by `armleocpu_ptw`. It sits between the MMU control logic and the page table walker. Address translation queries it first, and only a miss launches a walk. A successful walk result is written back with a WRITE command. Lookups take one cycle. A flush sweeps all sets over multiple cycles.

---
 rtl/armleocpu_tlb.sv | 198 +++++++++++++++++++
 tb/tb_armleocpu_tlb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_tlb.sv
// Set-associative Sv32 TLB: one-cycle lookup, write-back of PTW results, multi-cycle flush.
// Optional hit/miss performance counters are enabled by defining ARMLEOCPU_TLB_PERF_EN.
module armleocpu_tlb #(
    parameter int unsigned ENTRIES_W = 4,
    parameter int unsigned WAYS_W    = 1,
    localparam int unsigned WAY_IDX_W = (WAYS_W > 0) ? WAYS_W : 1
) (
    input  logic                 clk,
    input  logic                 async_rst_n,
    input  logic [1:0]           command,
    input  logic [19:0]          virtual_address,
    input  logic [7:0]           new_entry_access_bits,
    input  logic [21:0]          new_entry_physical_address,
    output logic                 busy,
    output logic                 resolve_done,
    output logic                 resolve_miss,
    output logic [7:0]           resolve_access_bits,
    output logic [21:0]          resolve_physical_address,
    output logic [WAY_IDX_W-1:0] resolve_way,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    localparam int unsigned SETS  = 1 << ENTRIES_W;
    localparam int unsigned WAYS  = 1 << WAYS_W;
    localparam int unsigned TAG_W = 20 - ENTRIES_W;

    localparam logic [1:0] CMD_RESOLVE        = 2'd1;
    localparam logic [1:0] CMD_WRITE          = 2'd2;
    localparam logic [1:0] CMD_INVALIDATE_ALL = 2'd3;

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e                 state_q, state_d;
    logic [ENTRIES_W-1:0]   flush_idx_q, flush_idx_d;
    logic [WAY_IDX_W-1:0]   rr_q, rr_d;

    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
    logic [6:0]                perm_q [SETS][WAYS];
    logic [21:0]               ppn_q  [SETS][WAYS];

    logic [ENTRIES_W-1:0] index;
    logic [TAG_W-1:0]     tag;
    assign index = virtual_address[ENTRIES_W-1:0];
    assign tag   = virtual_address[19:ENTRIES_W];

    // The V bit from the PTW is implied by a WRITE; stored valid is always set.
    logic unused_access_v;
    assign unused_access_v = new_entry_access_bits[0];

    logic                 lookup_hit;
    logic [WAY_IDX_W-1:0] lookup_way;
    logic                 invalid_found;
    logic [WAY_IDX_W-1:0] invalid_way;

    always_comb begin
        lookup_hit    = 1'b0;
        lookup_way    = '0;
        invalid_found = 1'b0;
        invalid_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lookup_hit && valid_q[index][WAY_IDX_W'(w)]
                    && (tag_q[index][WAY_IDX_W'(w)] == tag)) begin
                lookup_hit = 1'b1;
                lookup_way = WAY_IDX_W'(w);
            end
            if (!invalid_found && !valid_q[index][WAY_IDX_W'(w)]) begin
                invalid_found = 1'b1;
                invalid_way   = WAY_IDX_W'(w);
            end
        end
    end

    logic                 use_victim;
    logic [WAY_IDX_W-1:0] wr_way;
    logic [WAY_IDX_W-1:0] rr_next;

    assign use_victim = !lookup_hit && !invalid_found;
    assign wr_way     = lookup_hit ? lookup_way : (invalid_found ? invalid_way : rr_q);
    assign rr_next    = (WAYS_W == 0) ? '0 : rr_q + 1'b1;

    logic resolve_en;
    logic write_en;
    logic flush_clear;

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        rr_d        = rr_q;
        resolve_en  = 1'b0;
        write_en    = 1'b0;
        flush_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                case (command)
                    CMD_RESOLVE: resolve_en = 1'b1;
                    CMD_WRITE: begin
                        write_en = 1'b1;
                        if (use_victim) begin
                            rr_d = rr_next;
                        end
                    end
                    CMD_INVALIDATE_ALL: begin
                        state_d     = StFlush;
                        flush_idx_d = '0;
                        rr_d        = '0;
                    end
                    default: ;
                endcase
            end
            StFlush: begin
                flush_clear = 1'b1;
                if (flush_idx_q == ENTRIES_W'(SETS - 1)) begin
                    state_d = StIdle;
                end else begin
                    flush_idx_d = flush_idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= StIdle;
            flush_idx_q <= '0;
            rr_q        <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            rr_q        <= rr_d;
            if (flush_clear) begin
                valid_q[flush_idx_q] <= '0;
            end else if (write_en) begin
                valid_q[index][wr_way] <= 1'b1;
            end
        end
    end

    // Payload needs no reset: it is never observed unless its valid bit is set.
    always_ff @(posedge clk) begin
        if (write_en) begin
            tag_q[index][wr_way]  <= tag;
            perm_q[index][wr_way] <= new_entry_access_bits[7:1];
            ppn_q[index][wr_way]  <= new_entry_physical_address;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            resolve_done             <= 1'b0;
            resolve_miss             <= 1'b0;
            resolve_access_bits      <= '0;
            resolve_physical_address <= '0;
            resolve_way              <= '0;
        end else begin
            resolve_done             <= resolve_en;
            resolve_miss             <= resolve_en && !lookup_hit;
            resolve_access_bits      <= '0;
            resolve_physical_address <= '0;
            resolve_way              <= '0;
            if (resolve_en && lookup_hit) begin
                resolve_access_bits      <= {perm_q[index][lookup_way], 1'b1};
                resolve_physical_address <= ppn_q[index][lookup_way];
                resolve_way              <= lookup_way;
            end
        end
    end

    assign busy = (state_q == StFlush);

`ifdef ARMLEOCPU_TLB_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (resolve_en) begin
            if (lookup_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_armleocpu_tlb.sv
// Self-checking bench for armleocpu_tlb (default parameters): vector table, flush and
// mid-flush reset sequences, with a cycle-stamped scoreboard checked on the falling edge.
module tb_armleocpu_tlb;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_RES  = 2'd1;
    localparam logic [1:0] C_WR   = 2'd2;
    localparam logic [1:0] C_INV  = 2'd3;

`ifdef ARMLEOCPU_TLB_PERF_EN
    localparam logic [31:0] EXP_HIT_A  = 32'd1;
    localparam logic [31:0] EXP_MISS_A = 32'd1;
    localparam logic [31:0] EXP_HIT_B  = 32'd1;
    localparam logic [31:0] EXP_MISS_B = 32'd3;
`else
    localparam logic [31:0] EXP_HIT_A  = 32'd0;
    localparam logic [31:0] EXP_MISS_A = 32'd0;
    localparam logic [31:0] EXP_HIT_B  = 32'd0;
    localparam logic [31:0] EXP_MISS_B = 32'd0;
`endif

    logic        clk;
    logic        async_rst_n;
    logic [1:0]  command;
    logic [19:0] virtual_address;
    logic [7:0]  new_entry_access_bits;
    logic [21:0] new_entry_physical_address;
    logic        busy;
    logic        resolve_done;
    logic        resolve_miss;
    logic [7:0]  resolve_access_bits;
    logic [21:0] resolve_physical_address;
    logic [0:0]  resolve_way;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    armleocpu_tlb dut (
        .clk                        (clk),
        .async_rst_n                (async_rst_n),
        .command                    (command),
        .virtual_address            (virtual_address),
        .new_entry_access_bits      (new_entry_access_bits),
        .new_entry_physical_address (new_entry_physical_address),
        .busy                       (busy),
        .resolve_done               (resolve_done),
        .resolve_miss               (resolve_miss),
        .resolve_access_bits        (resolve_access_bits),
        .resolve_physical_address   (resolve_physical_address),
        .resolve_way                (resolve_way),
        .hit_count                  (hit_count),
        .miss_count                 (miss_count)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [19:0] va;
        logic [7:0]  bits;
        logic [21:0] ppn;
        logic        e_done;
        logic        e_miss;
        logic [7:0]  e_bits;
        logic [21:0] e_ppn;
        logic        e_way;
        logic        e_busy;
    } vec_t;

    typedef struct {
        int          cyc;
        string       name;
        logic        e_done;
        logic        e_miss;
        logic [7:0]  e_bits;
        logic [21:0] e_ppn;
        logic        e_way;
        logic        e_busy;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] cmd, input logic [19:0] va,
                                input logic [7:0] bits, input logic [21:0] ppn,
                                input logic ed, input logic em, input logic [7:0] eb,
                                input logic [21:0] ep, input logic ew, input logic ebusy);
        vec_t v;
        v.cmd = cmd; v.va = va; v.bits = bits; v.ppn = ppn;
        v.e_done = ed; v.e_miss = em; v.e_bits = eb; v.e_ppn = ep;
        v.e_way = ew; v.e_busy = ebusy;
        return v;
    endfunction

    // Shorthands: write (no response), hit, miss, idle.
    function automatic vec_t w(input logic [19:0] va, input logic [7:0] bits,
                               input logic [21:0] ppn, input logic ebusy);
        return mk(C_WR, va, bits, ppn, 1'b0, 1'b0, 8'h0, 22'h0, 1'b0, ebusy);
    endfunction
    function automatic vec_t rh(input logic [19:0] va, input logic [7:0] eb,
                                input logic [21:0] ep, input logic ew);
        return mk(C_RES, va, 8'h0, 22'h0, 1'b1, 1'b0, eb, ep, ew, 1'b0);
    endfunction
    function automatic vec_t rm(input logic [19:0] va);
        return mk(C_RES, va, 8'h0, 22'h0, 1'b1, 1'b1, 8'h0, 22'h0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t nop(input logic [1:0] cmd, input logic [19:0] va,
                                 input logic ebusy);
        return mk(cmd, va, 8'h5A, 22'h155555, 1'b0, 1'b0, 8'h0, 22'h0, 1'b0, ebusy);
    endfunction

    task automatic step(input vec_t v, input string name);
        exp_t e;
        command                    = v.cmd;
        virtual_address            = v.va;
        new_entry_access_bits      = v.bits;
        new_entry_physical_address = v.ppn;
        e.cyc = cyc + 1; e.name = name;
        e.e_done = v.e_done; e.e_miss = v.e_miss; e.e_bits = v.e_bits;
        e.e_ppn = v.e_ppn; e.e_way = v.e_way; e.e_busy = v.e_busy;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        command = C_NONE;
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            me = sbq.pop_front();
            chk({me.name, ".done"}, 32'(resolve_done), 32'(me.e_done));
            chk({me.name, ".miss"}, 32'(resolve_miss), 32'(me.e_miss));
            chk({me.name, ".bits"}, 32'(resolve_access_bits), 32'(me.e_bits));
            chk({me.name, ".ppn"}, 32'(resolve_physical_address), 32'(me.e_ppn));
            chk({me.name, ".way"}, 32'(resolve_way), 32'(me.e_way));
            chk({me.name, ".busy"}, 32'(busy), 32'(me.e_busy));
        end else begin
            chk("unexpected_done", 32'(resolve_done), 32'd0);
        end
    end

    localparam int NV = 22;
    vec_t vecs[NV];
    logic [19:0] post_flush_va[6];

    initial begin
        vecs[0]  = rm(20'h00012);
        vecs[1]  = w(20'h00012, 8'hCF, 22'h000001, 1'b0);
        vecs[2]  = rh(20'h00012, 8'hCF, 22'h000001, 1'b0);
        vecs[3]  = w(20'h00003, 8'h0E, 22'h000003, 1'b0);
        vecs[4]  = w(20'h00013, 8'h07, 22'h000013, 1'b0);
        vecs[5]  = w(20'h00023, 8'hC7, 22'h000023, 1'b0);
        vecs[6]  = rm(20'h00003);
        vecs[7]  = rh(20'h00013, 8'h07, 22'h000013, 1'b1);
        vecs[8]  = rh(20'h00023, 8'hC7, 22'h000023, 1'b0);
        vecs[9]  = w(20'h00013, 8'h03, 22'h2AAAAA, 1'b0);
        vecs[10] = rh(20'h00013, 8'h03, 22'h2AAAAA, 1'b1);
        vecs[11] = w(20'h00033, 8'h01, 22'h000033, 1'b0);
        vecs[12] = rh(20'h00033, 8'h01, 22'h000033, 1'b1);
        vecs[13] = rm(20'h00013);
        vecs[14] = rh(20'h00023, 8'hC7, 22'h000023, 1'b0);
        vecs[15] = w(20'h00043, 8'h0B, 22'h000043, 1'b0);
        vecs[16] = rh(20'h00043, 8'h0B, 22'h000043, 1'b0);
        vecs[17] = rm(20'h00023);
        vecs[18] = w(20'hFFFFF, 8'hFF, 22'h3FFFFF, 1'b0);
        vecs[19] = rh(20'hFFFFF, 8'hFF, 22'h3FFFFF, 1'b0);
        vecs[20] = rm(20'h7FFFF);
        vecs[21] = nop(C_NONE, 20'h00012, 1'b0);
        post_flush_va = '{20'h00003, 20'h00043, 20'h00033, 20'hFFFFF, 20'h00055, 20'h00023};

        async_rst_n                = 1'b0;
        command                    = C_NONE;
        virtual_address            = '0;
        new_entry_access_bits      = '0;
        new_entry_physical_address = '0;
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(resolve_done), 32'd0);
        chk("rst.miss", 32'(resolve_miss), 32'd0);
        chk("rst.bits", 32'(resolve_access_bits), 32'd0);
        chk("rst.ppn", 32'(resolve_physical_address), 32'd0);
        chk("rst.way", 32'(resolve_way), 32'd0);
        chk("rst.hit_count", hit_count, 32'd0);
        chk("rst.miss_count", miss_count, 32'd0);
        async_rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
            if (i == 2) begin
                chk("perf.hit_after_2", hit_count, EXP_HIT_A);
                chk("perf.miss_after_2", miss_count, EXP_MISS_A);
            end
        end

        // Flush: busy for 16 cycles; commands during busy are dropped.
        step(nop(C_INV, 20'h0, 1'b1), "flush_start");
        for (int k = 1; k <= 16; k++) begin
            if (k == 7) step(nop(C_RES, 20'h00012, 1'b1), "flush_mid_resolve");
            else if (k == 9) step(nop(C_WR, 20'h00055, 1'b1), "flush_mid_write");
            else if (k == 16) step(nop(C_RES, 20'h00043, 1'b0), "flush_last_resolve");
            else step(nop(C_NONE, 20'h0, (k < 16)), $sformatf("flush_cyc%0d", k));
        end
        step(rm(20'h00012), "after_flush_first");
        foreach (post_flush_va[j]) step(rm(post_flush_va[j]), $sformatf("after_flush%0d", j));

        // Round-robin restarts at way 0 after a flush.
        step(w(20'h00003, 8'h02, 22'h000103, 1'b0), "rr_w0");
        step(w(20'h00013, 8'h04, 22'h000113, 1'b0), "rr_w1");
        step(w(20'h00023, 8'h08, 22'h000123, 1'b0), "rr_w2");
        step(rh(20'h00023, 8'h09, 22'h000123, 1'b0), "rr_r23");
        step(rh(20'h00013, 8'h05, 22'h000113, 1'b1), "rr_r13");
        step(rm(20'h00003), "rr_r03");

        // Reset during the fifth flush cycle.
        step(w(20'h00012, 8'h0F, 22'h000005, 1'b0), "rf_w12");
        step(rh(20'h00012, 8'h0F, 22'h000005, 1'b0), "rf_r12");
        step(nop(C_INV, 20'h0, 1'b1), "rf_flush");
        for (int k = 1; k <= 4; k++) step(nop(C_NONE, 20'h0, 1'b1), $sformatf("rf_cyc%0d", k));
        @(negedge clk);
        #1;
        async_rst_n = 1'b0;
        #1;
        chk("rf.busy_in_reset", 32'(busy), 32'd0);
        chk("rf.done_in_reset", 32'(resolve_done), 32'd0);
        chk("rf.hit_count_reset", hit_count, 32'd0);
        chk("rf.miss_count_reset", miss_count, 32'd0);
        @(posedge clk);
        #1;
        async_rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(rm(20'h00012), "rf_post_r12");
        step(rm(20'h00013), "rf_post_r13");
        step(w(20'h00004, 8'h10, 22'h000204, 1'b0), "rf_w04");
        step(w(20'h00014, 8'h20, 22'h000214, 1'b0), "rf_w14");
        step(w(20'h00024, 8'h40, 22'h000224, 1'b0), "rf_w24");
        step(rh(20'h00024, 8'h41, 22'h000224, 1'b0), "rf_r24");
        step(rm(20'h00004), "rf_r04");

        @(negedge clk);
        #1;
        chk("perf.hit_final", hit_count, EXP_HIT_B);
        chk("perf.miss_final", miss_count, EXP_MISS_B);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
